// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared fifo_syn / fifo_rd_stream types and constants
package fifo_pkg;

    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 4;

    // Buffered-word count (0..3) and a pointer into the 3-entry read buffer.
    typedef logic [1:0] occ_t;
    typedef logic [1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - 3-entry circular buffer with push/pop, occupancy and registered head data
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [0:2];
    logic [WIDTH-1:0] mem_d [0:2];
    ptr_t             head_q, head_d;
    ptr_t             tail_q, tail_d;
    occ_t             occ_q, occ_d;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // A push never targets the head slot while it is presented, so head data stays stable under stall.
    assign occ       = occ_q;
    assign head_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - fifo_syn read adapter to a framed valid/ready stream; RD_STREAM_STAT_EN adds beat/stall counters
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rd,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready
`ifdef RD_STREAM_STAT_EN
    ,
    output logic [15:0]      beat_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int                CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);

    occ_t             occ;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       committed;
    logic             pop;

    rd_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (fifo_q),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data)
    );

    // Issue only from registered state so m_ready never reaches fifo_rd.
    assign committed = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_rd   = !rst && !fifo_empty && (committed <= 3'd2);
    assign m_valid   = (occ != 2'd0);
    assign pop       = m_valid && m_ready;
    assign m_last    = (cnt_q == LAST_CNT) && m_valid;

    always_comb begin
        inflight_d = fifo_rd;
        cnt_d      = cnt_q;
        if (pop) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef RD_STREAM_STAT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
        if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed self-checking bench for fifo_rd_stream with a behavioural fifo_syn
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_q;
    logic       fifo_rd;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
`ifdef RD_STREAM_STAT_EN
    logic [15:0] beat_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] fmem [$];

    fifo_rd_stream #(
        .WIDTH     (8),
        .BURST_LEN (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready)
`ifdef RD_STREAM_STAT_EN
        ,
        .beat_cnt   (beat_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // fifo_syn model: read data appears the cycle after fifo_rd, reset empties it.
    always begin
        @(posedge clk);
        if (rst) begin
            #1;
            fmem.delete();
            fifo_q     = 8'h00;
            fifo_empty = 1'b1;
        end else if (fifo_rd) begin
            #1;
            if (fmem.size() > 0) begin
                fifo_q = fmem.pop_front();
            end
            fifo_empty = (fmem.size() == 0);
        end
    end

    task automatic push(input logic [7:0] w);
        fmem.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({fifo_rd, m_valid, m_last} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl rd/valid/last got %b exp 000", {fifo_rd, m_valid, m_last});
        end
        checks++;
        if (m_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h exp 00", m_data);
        end
        rst     = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] exp_d [5];
        exp_d = '{8'hab, 8'h12, 8'h34, 8'h56, 8'h78};
        apply_reset();
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(exp_d[i]);
        #1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (fifo_rd !== (c < 5)) begin
                errors++;
                $display("FAIL stream_rd c%0d got %b exp %b", c, fifo_rd, (c < 5));
            end
            checks++;
            if (m_valid !== (c >= 2 && c < 7)) begin
                errors++;
                $display("FAIL stream_valid c%0d got %b exp %b", c, m_valid, (c >= 2 && c < 7));
            end
            if (c >= 2 && c < 7) begin
                checks++;
                if (m_data !== exp_d[c-2] || m_last !== (c == 5)) begin
                    errors++;
                    $display("FAIL stream_data c%0d got %h/%b exp %h/%b", c, m_data, m_last, exp_d[c-2], (c == 5));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [5];
        logic [7:0] got [$];
        int rd_stall = 0;
        int rd_total = 0;
        exp_d = '{8'hab, 8'h12, 8'h34, 8'h56, 8'h78};
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) push(exp_d[i]);
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            m_ready = (c >= 10);
            #1;
            if (fifo_rd) begin
                rd_total++;
                if (c < 10) rd_stall++;
            end
            if (c >= 2 && c < 10) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== 8'hab) begin
                    errors++;
                    $display("FAIL bp_hold c%0d got %b/%h exp 1/ab", c, m_valid, m_data);
                end
            end
            if (m_valid && m_ready) got.push_back(m_data);
        end
        checks++;
        if (rd_stall !== 3) begin
            errors++;
            $display("FAIL bp_rd_pulses got %0d exp 3", rd_stall);
        end
        checks++;
        if (rd_total !== 5 || got.size() !== 5) begin
            errors++;
            $display("FAIL bp_counts rd %0d words %0d exp 5 5", rd_total, got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL bp_order idx %0d got %h exp %h", i, got[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_toggle_ready();
        logic [7:0] got [$];
        logic       lst [$];
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        logic       prev_last  = 1'b0;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            m_ready = (c % 2 == 0);
            #1;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL toggle_stable c%0d got %b/%h/%b exp 1/%h/%b", c, m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                lst.push_back(m_last);
            end
        end
        checks++;
        if (got.size() !== 8) begin
            errors++;
            $display("FAIL toggle_count got %0d exp 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== 8'(i) || lst[i] !== (i == 3 || i == 7)) begin
                    errors++;
                    $display("FAIL toggle_word idx %0d got %h/%b exp %h/%b", i, got[i], lst[i], 8'(i), (i == 3 || i == 7));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp_d [4];
        logic [7:0] got [$];
        logic       lst [$];
        int         hs = 0;
        exp_d = '{8'h9a, 8'h9b, 8'h9c, 8'h9d};
        apply_reset();
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h11 * 8'(i + 1));
        for (int c = 0; c < 20 && hs < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (m_valid && m_ready) hs++;
        end
        checks++;
        if (hs !== 2) begin
            errors++;
            $display("FAIL midrst_pre got %0d handshakes exp 2", hs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({fifo_rd, m_valid, m_last} !== 3'b000 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_clear got %b/%h exp 000/00", {fifo_rd, m_valid, m_last}, m_data);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) push(exp_d[i]);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                lst.push_back(m_last);
            end
        end
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL midrst_count got %0d exp 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_d[i] || lst[i] !== (i == 3)) begin
                    errors++;
                    $display("FAIL midrst_word idx %0d got %h/%b exp %h/%b", i, got[i], lst[i], exp_d[i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_empty();
        int bad = 0;
        apply_reset();
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (fifo_rd !== 1'b0 || m_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL empty_idle got %0d active cycles exp 0", bad);
        end
    endtask

`ifdef RD_STREAM_STAT_EN
    task automatic test_stats();
        int stalls = 0;
        apply_reset();
        #1;
        checks++;
        if (beat_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stat_reset got %0d/%0d exp 0/0", beat_cnt, stall_cnt);
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
        for (int c = 0; c < 25; c++) begin
            if (c > 0) @(negedge clk);
            m_ready = !(m_valid && stalls < 3);
            if (m_valid && !m_ready) stalls++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (beat_cnt !== 16'd5 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stat_counts got %0d/%0d exp 5/3", beat_cnt, stall_cnt);
        end
        apply_reset();
        #1;
        checks++;
        if (beat_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stat_rerst got %0d/%0d exp 0/0", beat_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        rst        = 1'b1;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_q     = 8'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle_ready();
        test_mid_reset();
        test_empty();
`ifdef RD_STREAM_STAT_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
